// File: rtl/geiger_pkg.sv
// Shared definitions for the Geiger measurement controller: FSM encoding and default widths.
package geiger_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int WIN_W_DEFAULT = 16;
  localparam int DT_W_DEFAULT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/dead_time_gate.sv
// Post-pulse blanking: passes a pulse only when the dead counter is idle, then blanks
// the following load cycles.
module dead_time_gate
  import geiger_pkg::*;
#(
  parameter int DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            enable,
  input  logic            pulse,
  input  logic [DT_W-1:0] load,
  output logic            qualified
);

  logic [DT_W-1:0] dead_reg;

  assign qualified = enable && pulse && (dead_reg == '0);

  // Decrement stops at zero, so the counter never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      dead_reg <= '0;
    end else if (qualified) begin
      dead_reg <= load;
    end else if (dead_reg != '0) begin
      dead_reg <= dead_reg - DT_W'(1);
    end
  end

endmodule

// File: rtl/geiger_measure_ctrl.sv
// Measurement controller: counts dead-time-qualified pulses over a programmable window
// and presents the saturating count through a valid/ready result handshake.
module geiger_measure_ctrl
  import geiger_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int WIN_W = WIN_W_DEFAULT,
  parameter int DT_W  = DT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] window_len,
  input  logic [DT_W-1:0]  dead_time,
  input  logic             pulse_in,
  output logic             src_ena,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_reg, state_next;
  logic [WIN_W-1:0] win_left_reg;
  logic [DT_W-1:0]  dead_len_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic             accept;
  logic             in_measure;
  logic             hit;

  // start together with abort is not an accepted start.
  assign accept     = (state_reg == ST_IDLE) && start && !abort;
  assign in_measure = (state_reg == ST_MEASURE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (window_len == '0) ? ST_REPORT : ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (win_left_reg <= WIN_W'(1)) begin
          state_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (abort || result_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  dead_time_gate #(
    .DT_W(DT_W)
  ) u_gate (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .enable   (in_measure),
    .pulse    (pulse_in),
    .load     (dead_len_reg),
    .qualified(hit)
  );

  // The window counter holds the cycles still to run, including the current one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_left_reg <= '0;
      dead_len_reg <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      win_left_reg <= window_len;
      dead_len_reg <= dead_time;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (in_measure) begin
      if (win_left_reg != '0) begin
        win_left_reg <= win_left_reg - WIN_W'(1);
      end
      if (hit) begin
        if (count_reg == CNT_MAX) begin
          overflow_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + CNT_W'(1);
        end
      end
    end
  end

  assign src_ena      = in_measure;
  assign busy         = (state_reg != ST_IDLE);
  assign result_valid = (state_reg == ST_REPORT);
  assign count        = count_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_geiger_measure_ctrl.sv
// Scoreboard bench for geiger_measure_ctrl: directed corner runs followed by random runs,
// expected results derived from a pulse-list reference model.
module tb_geiger_measure_ctrl;

  localparam int CNT_W   = 4;
  localparam int WIN_W   = 16;
  localparam int DT_W    = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pulse_in = 1'b0;
  logic             result_ready = 1'b0;
  logic [WIN_W-1:0] window_len = '0;
  logic [DT_W-1:0]  dead_time = '0;
  logic             src_ena, busy, overflow, result_valid;
  logic [CNT_W-1:0] count;

  geiger_measure_ctrl #(
    .CNT_W(CNT_W),
    .WIN_W(WIN_W),
    .DT_W (DT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .window_len  (window_len),
    .dead_time   (dead_time),
    .pulse_in    (pulse_in),
    .src_ena     (src_ena),
    .busy        (busy),
    .count       (count),
    .overflow    (overflow),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit ovf;
    int win;
    int start_cyc;
    bit discard;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ready_mode = 0;  // 0 random, 1 held low, 2 held high

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; result_ready follows ready_mode.
  task automatic tick();
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       result_ready = 1'b0;
      2:       result_ready = 1'b1;
      default: result_ready = ($urandom_range(0, 2) == 0);
    endcase
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_src_ena"}, src_ena, 0);
    check({tag, "_valid"}, result_valid, 0);
  endtask

  // mode: 0 normal, 1 abort in window cycle a, 2 reset in window cycle a,
  //       3 abort in REPORT with result_ready high, 4 ready held low 7 cycles
  task automatic run(input int win, input int dt, input int dens, input int mode,
                     input int a, input int rmode);
    bit   pat[$];
    int   n = 0;
    int   nxt = 1;
    int   t = 0;
    exp_t e;
    for (int k = 1; k <= win; k++) pat.push_back(dens >= 100 ? 1'b1 : ($urandom_range(0, 99) < dens));
    // A pulse in window cycle k counts if at least dt cycles passed since the last counted one.
    for (int k = 1; k <= win; k++) begin
      if (pat[k-1] && k >= nxt) begin
        n++;
        nxt = k + dt + 1;
      end
    end
    e.cnt       = (n > CNT_MAX) ? CNT_MAX : n;
    e.ovf       = (n > CNT_MAX);
    e.win       = win;
    e.start_cyc = cyc;
    e.discard   = (mode == 3);
    if (mode == 0 || mode == 3 || mode == 4) sb.push_back(e);
    $display("txn win=%0d dt=%0d dens=%0d mode=%0d a=%0d exp_count=%0d exp_ovf=%0d",
             win, dt, dens, mode, a, e.cnt, e.ovf);
    ready_mode = (mode == 4) ? 1 : rmode;
    start      = 1'b1;
    window_len = WIN_W'(win);
    dead_time  = DT_W'(dt);
    pulse_in   = 1'($urandom_range(0, 1));
    for (int k = 1; k <= win; k++) begin
      tick();
      start    = 1'($urandom_range(0, 1));
      pulse_in = pat[k-1];
      if ((mode == 1 || mode == 2) && k == a) begin
        if (mode == 1) abort = 1'b1;
        else rst_n = 1'b0;
        tick();
        abort    = 1'b0;
        rst_n    = 1'b1;
        start    = 1'b0;
        pulse_in = 1'b0;
        check_idle(mode == 1 ? "abort" : "reset");
        if (mode == 2) begin
          check("reset_count", count, 0);
          check("reset_overflow", overflow, 0);
        end
        repeat (3) tick();
        check("after_cancel_valid", result_valid, 0);
        return;
      end
    end
    tick();
    start    = 1'b0;
    pulse_in = 1'($urandom_range(0, 1));
    if (mode == 3 || mode == 4) begin
      while (!result_valid && t < 50) begin
        tick();
        t++;
      end
      check("valid_seen", result_valid, 1);
      if (mode == 3) begin
        abort        = 1'b1;
        result_ready = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("report_abort");
      end else begin
        repeat (6) tick();
        ready_mode = 2;
        tick();
      end
    end
    t = 0;
    while (busy && t < 200) begin
      tick();
      pulse_in = 1'($urandom_range(0, 1));
      t++;
    end
    check("done_busy", busy, 0);
    tick();
  endtask

  // Monitor: checks latency and window length on the rising result_valid, stability while
  // held, and pops the scoreboard on handshake or abort.
  initial begin
    logic             prev_valid;
    logic [CNT_W-1:0] prev_cnt;
    logic             prev_ovf;
    int               src_cycles;
    prev_valid = 1'b0;
    prev_cnt   = '0;
    prev_ovf   = 1'b0;
    src_cycles = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        src_cycles = 0;
      end else begin
        if (!busy) src_cycles = 0;
        else if (src_ena) src_cycles++;
        if (result_valid) begin
          if (sb.size() == 0) begin
            check("spurious_valid", 1, 0);
          end else begin
            if (!prev_valid) begin
              check("latency", cyc - sb[0].start_cyc, sb[0].win + 1);
              check("src_ena_cycles", src_cycles, sb[0].win);
            end else begin
              check("count_stable", count, prev_cnt);
              check("overflow_stable", overflow, prev_ovf);
            end
            if (abort) begin
              check("abort_discard", 1, sb[0].discard);
              void'(sb.pop_front());
            end else if (result_ready) begin
              check("handshake_expected", 0, sb[0].discard);
              check("count", count, sb[0].cnt);
              check("overflow", overflow, sb[0].ovf);
              void'(sb.pop_front());
            end
          end
        end
        prev_valid = result_valid;
        prev_cnt   = count;
        prev_ovf   = overflow;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int win, dt, dens, mode, a, sel;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_src_ena", src_ena, 0);
    check("rst_valid", result_valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick();

    run(10, 0, 100, 0, 0, 2);
    run(20, 3, 100, 0, 0, 2);
    run(20, 0, 100, 0, 0, 2);
    run(0, 5, 100, 0, 0, 2);
    run(5, 1, 100, 4, 0, 0);
    run(10, 0, 100, 1, 4, 2);
    run(10, 0, 100, 2, 4, 2);
    run(8, 2, 100, 3, 0, 0);

    start = 1'b1;
    abort = 1'b1;
    window_len = WIN_W'(6);
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 0);
    tick();

    for (int i = 0; i < 60; i++) begin
      win  = $urandom_range(0, 30);
      dt   = $urandom_range(0, 15);
      sel  = $urandom_range(0, 2);
      dens = (sel == 0) ? 10 : (sel == 1) ? 50 : 100;
      sel  = $urandom_range(0, 9);
      mode = (sel <= 5) ? 0 : sel - 5;
      if ((mode == 1 || mode == 2) && win == 0) win = 1;
      a = (win > 0) ? $urandom_range(1, win) : 0;
      run(win, dt, dens, mode, a, $urandom_range(0, 1) * 2);
    end

    repeat (5) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/geiger_measure_ctrl.md
GEIGER_MEASURE_CTRL -- requirements
Module: geiger_measure_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: pulse-count width.
REQ-002 SHALL have parameter WIN_W, default 16: measurement-window length width, in cycles.
REQ-003 SHALL have parameter DT_W, default 4: dead-time width, in cycles.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port start  input  1  request a measurement; honoured only in IDLE.
REQ-007 SHALL have port abort  input  1  cancel a measurement in progress.
REQ-008 SHALL have port window_len  input  WIN_W  window length; sampled when start is accepted.
REQ-009 SHALL have port dead_time  input  DT_W  post-pulse blanking in cycles; sampled when start is accepted.
REQ-010 SHALL have port pulse_in  input  1  pulse from the pulse-source block.
REQ-011 SHALL have port src_ena  output  1  enable to the pulse-source block.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port count  output  CNT_W  result count; valid while result_valid is high.
REQ-014 SHALL have port overflow  output  1  count saturated during the window.
REQ-015 SHALL have port result_valid  output  1  result available.
REQ-016 SHALL have port result_ready  input  1  consumer accepts the result.

Function
REQ-017 SHALL implement the FSM states IDLE, MEASURE and REPORT.
REQ-018 IDLE with start=1 SHALL latch window_len and dead_time, clear count, overflow and the dead counter, and go to MEASURE; if the latched window_len=0 it SHALL go to REPORT instead, with count=0.
REQ-019 MEASURE SHALL drive src_ena=1 for exactly window_len consecutive cycles, then go to REPORT; src_ena SHALL be 0 in every other state.
REQ-020 Timing: start sampled in cycle 0 -> src_ena high in cycles 1..N -> result_valid high from cycle N+1.
REQ-021 In MEASURE, pulse_in=1 with the dead counter at 0 SHALL increment count and load the dead counter with dead_time.
REQ-022 In MEASURE, pulse_in=1 with the dead counter nonzero SHALL be ignored; the dead counter SHALL decrement by 1 each cycle while nonzero.
REQ-023 dead_time=0 SHALL allow a pulse to be counted in every cycle.
REQ-024 pulse_in SHALL be ignored outside MEASURE.
REQ-025 count SHALL saturate at 2^CNT_W-1; a pulse that would otherwise be counted while count is saturated SHALL set overflow, which stays set until the next accepted start.
REQ-026 A pulse counted in the final MEASURE cycle SHALL be included in the reported count.
REQ-027 REPORT SHALL hold result_valid=1 with count and overflow stable until result_ready=1, then go to IDLE in the next cycle; result_valid SHALL be 0 in IDLE.
REQ-028 abort=1 in MEASURE or REPORT SHALL go to IDLE next cycle and discard the result; abort SHALL override window expiry and result_ready in the same cycle.
REQ-029 start SHALL be ignored in MEASURE and REPORT.
REQ-030 start and abort both high in IDLE SHALL leave the block in IDLE.

Reset
REQ-031 rst_n=0 at a rising clk edge SHALL force IDLE, count=0, overflow=0, result_valid=0, src_ena=0, busy=0, and clear all internal counters.
REQ-032 Reset SHALL take effect from any state, including mid-window; no result SHALL be produced for an interrupted measurement.

Structure
REQ-033 The FSM state encoding and the default widths CNT_W, WIN_W and DT_W SHALL reside in the shared package geiger_pkg.
REQ-034 The dead-time blanking SHALL be one sub-module, dead_time_gate: inputs pulse, load value and enable; output a qualified pulse.
REQ-035 All counters SHALL be non-wrapping and free of combinational loops.

Verification
REQ-036 window_len=10, dead_time=0, pulse_in held at 1 -> src_ena high for exactly 10 cycles; count=10; overflow=0.
REQ-037 window_len=20, dead_time=3, pulse_in held at 1 -> count=5, i.e. counted in window cycles 1, 5, 9, 13 and 17.
REQ-038 CNT_W=4, window_len=20, dead_time=0, pulse_in held at 1 -> count=15, overflow=1.
REQ-039 window_len=0, start pulsed -> result_valid high in the cycle after start; count=0; src_ena never high.
REQ-040 result_ready held at 0 for 7 cycles, then 1 -> result_valid and count stable for all 8 cycles; IDLE follows; busy=0.
REQ-041 abort in window cycle 4 of 10, and rst_n low in window cycle 4 of a second run -> each gives IDLE next cycle, no result_valid, src_ena=0.
